lz77_enc_ctrl: RTL and testbench

//  Sequencer for one LZ77 encoder core (9-char search, 8-char look-ahead, '$'-terminated image).

---
 rtl/lz77_enc_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_lz77_enc_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz77_enc_ctrl.sv
// lz77_enc_ctrl: sequencer for one LZ77 encoder core.
// Starts an image on command, holds the core in reset for one cycle, streams
// exactly IMG_LEN characters from a valid/ready source into the core, captures
// the core's one-cycle token strobes into a small FIFO, drains that FIFO to a
// valid/ready sink and reports completion or a sticky error code.
module lz77_enc_ctrl #(
  parameter int IMG_LEN    = 2049,   // chars per image, trailing '$' included
  parameter int FIFO_DEPTH = 4,      // token FIFO entries, power of 2, >= 2
  parameter int WDOG_CYC   = 65535   // max ENC cycles between tokens
) (
  input  logic        clk,
  input  logic        reset,         // synchronous, active-low
  input  logic        start,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic        core_reset,
  output logic [7:0]  core_char,
  input  logic        core_valid,
  input  logic [3:0]  core_offset,
  input  logic [2:0]  core_mlen,
  input  logic [7:0]  core_cnxt,
  input  logic        core_finish,
  output logic        tok_valid,
  output logic [14:0] tok_data,
  input  logic        tok_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [11:0] tok_cnt
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CHAR_W = $clog2(IMG_LEN + 1);
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [CHAR_W-1:0] LAST_CHAR_C = CHAR_W'(IMG_LEN - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST_C = WDOG_W'(WDOG_CYC - 1);
  localparam logic [11:0]       TOK_MAX_C   = 12'hfff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_LOAD,
    S_ENC,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state;
  logic [CHAR_W-1:0]   char_cnt;
  logic [WDOG_W-1:0]   wdog;

  // Token FIFO storage and bookkeeping.
  logic [14:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;

  // Per-cycle decoded events.
  logic                push;
  logic                pop;
  logic                full;
  logic                wr_en;
  logic                overflow;
  logic                wdog_exp;
  logic                load_err;
  logic                start_acc;
  logic                flush;
  logic [14:0]         push_data;
  logic [PTR_W-1:0]    rd_next;
  logic [CNT_W-1:0]    cnt_after_pop;
  logic [CNT_W-1:0]    cnt_next;

  // Character path: the core sees source data only while loading a valid char.
  always_comb begin
    // NOTE: the default comes first so every path assigns core_char and no latch is inferred.
    core_char = 8'h00;
    if (state == S_LOAD && src_valid) begin
      core_char = src_data;
    end
  end

  // Event decode shared by the FSM and the FIFO.
  always_comb begin
    push          = (state == S_ENC) && core_valid;
    pop           = tok_valid && tok_ready;
    full          = (fifo_cnt == DEPTH_C);
    // A push into a full FIFO is still accepted when the head leaves this cycle.
    wr_en         = push && (!full || pop);
    overflow      = push && full && !pop;
    wdog_exp      = (state == S_ENC) && !core_valid && (wdog == WDOG_LAST_C);
    load_err      = (state == S_LOAD) && !src_valid;
    start_acc     = (state == S_IDLE) && start;
    flush         = start_acc || overflow || wdog_exp || load_err || (state == S_ERR);
    push_data     = {core_offset, core_mlen, core_cnxt};
    rd_next       = rd_ptr + PTR_W'(pop);
    cnt_after_pop = fifo_cnt - CNT_W'(pop);
    cnt_next      = cnt_after_pop + CNT_W'(wr_en);
  end

  // Control FSM: state, registered handshakes to core and source, status and counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      core_reset <= 1'b1;
      src_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 2'b00;
      tok_cnt    <= '0;
      char_cnt   <= '0;
      wdog       <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop here samples pre-edge values.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          core_reset <= 1'b1;
          src_ready  <= 1'b0;
          busy       <= 1'b0;
          if (start) begin
            state    <= S_CRST;
            busy     <= 1'b1;
            err      <= 2'b00;
            tok_cnt  <= '0;
            char_cnt <= '0;
            wdog     <= '0;
          end
        end

        S_CRST: begin
          state      <= S_LOAD;
          core_reset <= 1'b0;
          src_ready  <= 1'b1;
        end

        S_LOAD: begin
          if (!src_valid) begin
            // The core cannot stall, so a missing char aborts the image.
            err[0]     <= 1'b1;
            state      <= S_ERR;
            core_reset <= 1'b1;
            src_ready  <= 1'b0;
          end else begin
            char_cnt <= char_cnt + CHAR_W'(1);
            if (char_cnt == LAST_CHAR_C) begin
              state     <= S_ENC;
              src_ready <= 1'b0;
            end
          end
        end

        S_ENC: begin
          if (wr_en && tok_cnt != TOK_MAX_C) begin
            tok_cnt <= tok_cnt + 12'd1;
          end
          wdog <= core_valid ? '0 : wdog + WDOG_W'(1);
          if (overflow) begin
            err[1]     <= 1'b1;
            state      <= S_ERR;
            core_reset <= 1'b1;
          end else if (core_finish) begin
            state <= S_DRAIN;
          end else if (wdog_exp) begin
            err[1]     <= 1'b1;
            state      <= S_ERR;
            core_reset <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (fifo_cnt == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          core_reset <= 1'b1;
        end

        S_ERR: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          core_reset <= 1'b1;
        end

        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          core_reset <= 1'b1;
          src_ready  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and the registered head presented to the sink.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      tok_valid <= 1'b0;
      tok_data  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_next;
      fifo_cnt  <= cnt_next;
      tok_valid <= (cnt_next != '0);
      // When the FIFO is otherwise empty the new token becomes the head directly;
      // otherwise the head is the oldest remaining stored entry.
      if (wr_en && cnt_after_pop == '0) begin
        tok_data <= push_data;
      end else begin
        tok_data <= mem[rd_next];
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the token storage is not reset; fifo_cnt and tok_valid qualify every entry.
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: tb/tb_lz77_enc_ctrl.sv
// tb_lz77_enc_ctrl: self-checking bench for lz77_enc_ctrl.
// A table of short vectors covers reset and the first handshake steps; full
// images are then streamed while the bench plays the encoder core, and a
// queue-based model of the token path predicts tokens, counts and errors.
module tb_lz77_enc_ctrl;

  localparam int IMG_LEN = 2049;
  localparam int FD      = 4;
  localparam int WDOG    = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = 8'h00;
  logic        src_ready;
  logic        core_reset;
  logic [7:0]  core_char;
  logic        core_valid = 1'b0;
  logic [3:0]  core_offset = 4'h0;
  logic [2:0]  core_mlen = 3'h0;
  logic [7:0]  core_cnxt = 8'h00;
  logic        core_finish = 1'b0;
  logic        tok_valid;
  logic [14:0] tok_data;
  logic        tok_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [11:0] tok_cnt;

  always #5 clk = ~clk;

  lz77_enc_ctrl #(
    .IMG_LEN   (IMG_LEN),
    .FIFO_DEPTH(FD),
    .WDOG_CYC  (WDOG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .core_reset (core_reset),
    .core_char  (core_char),
    .core_valid (core_valid),
    .core_offset(core_offset),
    .core_mlen  (core_mlen),
    .core_cnxt  (core_cnxt),
    .core_finish(core_finish),
    .tok_valid  (tok_valid),
    .tok_data   (tok_data),
    .tok_ready  (tok_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .tok_cnt    (tok_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] rand_tok();
    logic [31:0] r;
    r = $urandom;
    return r[14:0];
  endfunction

  // Behavioural model of the token path: where the image is, what the sink should see.
  typedef enum {P_IDLE, P_ENC, P_DRAIN, P_DONE, P_ERR} phase_t;
  phase_t      m_phase = P_IDLE;
  logic [14:0] mq[$];
  int          m_tokcnt = 0;
  int          m_idle_run = 0;
  logic [1:0]  m_err = 2'b00;
  int          done_seen = 0;
  logic [14:0] last_pop = '0;

  // One cycle after the char stream: drive the core side and the sink, then compare.
  task automatic enc_cycle(input bit v, input bit rdy, input bit fin, input logic [14:0] tk);
    bit          pop;
    bit          push;
    bit          was_empty;
    int          sz;
    logic [31:0] r;
    r = $urandom;
    src_valid   = 1'b1;
    src_data    = r[7:0] | 8'h01;
    core_valid  = v;
    {core_offset, core_mlen, core_cnxt} = tk;
    core_finish = fin;
    tok_ready   = rdy;
    #1;
    check("core_char_outside_load", core_char, 8'h00);
    sz        = mq.size();
    was_empty = (sz == 0);
    pop       = !was_empty && rdy;
    push      = v && (m_phase == P_ENC);
    if (pop) last_pop = tok_data;
    step();
    case (m_phase)
      P_ENC: begin
        if (push && !pop && sz == FD) begin
          m_phase = P_ERR;
          m_err[1] = 1'b1;
          mq.delete();
        end else begin
          if (pop) void'(mq.pop_front());
          if (push) begin
            mq.push_back(tk);
            if (m_tokcnt < 4095) m_tokcnt++;
            m_idle_run = 0;
          end else begin
            m_idle_run++;
          end
          if (fin) begin
            m_phase = P_DRAIN;
          end else if (m_idle_run == WDOG) begin
            m_phase = P_ERR;
            m_err[1] = 1'b1;
            mq.delete();
          end
        end
      end
      P_DRAIN: begin
        if (was_empty) m_phase = P_DONE;
        else if (pop) void'(mq.pop_front());
      end
      P_DONE:  m_phase = P_IDLE;
      P_ERR:   m_phase = P_IDLE;
      default: ;
    endcase
    check("tok_valid", tok_valid, mq.size() != 0);
    if (mq.size() != 0) check("tok_data", tok_data, mq[0]);
    check("tok_cnt", tok_cnt, m_tokcnt);
    check("done", done, m_phase == P_DONE);
    check("err", err, m_err);
    check("busy", busy, m_phase != P_IDLE);
    check("core_reset", core_reset, m_phase inside {P_ERR, P_IDLE});
    check("src_ready_outside_load", src_ready, 1'b0);
    if (done) done_seen++;
    core_valid  = 1'b0;
    core_finish = 1'b0;
  endtask

  // Run cycles with the sink ready until the model says the controller is idle again.
  task automatic drain();
    for (int k = 0; k < 20 && m_phase != P_IDLE; k++) enc_cycle(1'b0, 1'b1, 1'b0, '0);
    check("drain_bound", m_phase == P_IDLE, 1'b1);
  endtask

  // Start an image and stream "ABAB...$"; drop_at removes one char, start_at re-pulses start.
  task automatic load_image(input int drop_at, input int start_at);
    logic [7:0] ch;
    start = 1'b1;
    src_valid = 1'b0;
    step();
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_core_reset", core_reset, 1'b1);
    check("start_err_clear", err, 2'b00);
    check("start_tok_cnt_clear", tok_cnt, 12'd0);
    step();
    check("crst_src_ready", src_ready, 1'b1);
    check("crst_core_reset", core_reset, 1'b0);
    m_err = 2'b00;
    m_tokcnt = 0;
    m_idle_run = 0;
    mq.delete();
    for (int i = 0; i < IMG_LEN; i++) begin
      ch = (i == IMG_LEN - 1) ? 8'h24 : ((i % 2 == 1) ? 8'h42 : 8'h41);
      src_valid = (i != drop_at);
      src_data  = ch;
      start     = (i == start_at);
      #1;
      check("load_core_char", core_char, src_valid ? ch : 8'h00);
      step();
      start = 1'b0;
      if (i == drop_at) begin
        check("underrun_err", err, 2'b01);
        check("underrun_core_reset", core_reset, 1'b1);
        check("underrun_src_ready", src_ready, 1'b0);
        check("underrun_busy_err_state", busy, 1'b1);
        src_valid = 1'b0;
        step();
        check("underrun_busy_idle", busy, 1'b0);
        check("underrun_core_reset_idle", core_reset, 1'b1);
        check("underrun_err_sticky", err, 2'b01);
        check("underrun_no_done", done, 1'b0);
        m_phase = P_IDLE;
        m_err = 2'b01;
        return;
      end
      check("load_src_ready", src_ready, i != IMG_LEN - 1);
      check("load_busy", busy, 1'b1);
      check("load_core_reset", core_reset, 1'b0);
    end
    src_valid = 1'b0;
    m_phase = P_ENC;
  endtask

  typedef struct {
    string      name;
    bit         rst_n;
    bit         st;
    bit         sv;
    logic [7:0] sd;
    bit         chk_char;
    logic [7:0] exp_char;
    bit         exp_cr;
    bit         exp_sr;
    bit         exp_busy;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          n;
    bit          v;
    logic [14:0] tk;

    // name, reset, start, src_valid, src_data, chk_char, exp_char, core_reset, src_ready, busy, err
    vecs[0] = '{"reset_entry",       1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[1] = '{"idle_hold",         1'b1, 1'b0, 1'b1, 8'h41, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[2] = '{"start_to_crst",     1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[3] = '{"crst_to_load",      1'b1, 1'b0, 1'b1, 8'h41, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 2'b00};
    vecs[4] = '{"load_char",         1'b1, 1'b0, 1'b1, 8'h5a, 1'b1, 8'h5a, 1'b0, 1'b1, 1'b1, 2'b00};
    vecs[5] = '{"load_underrun",     1'b1, 1'b0, 1'b0, 8'h77, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[6] = '{"err_ignores_start", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[7] = '{"restart_clears",    1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[8] = '{"reset_from_crst",   1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00};

    for (int i = 0; i < 9; i++) begin
      reset     = vecs[i].rst_n;
      start     = vecs[i].st;
      src_valid = vecs[i].sv;
      src_data  = vecs[i].sd;
      #1;
      if (vecs[i].chk_char) check({vecs[i].name, "_core_char"}, core_char, vecs[i].exp_char);
      step();
      check({vecs[i].name, "_core_reset"}, core_reset, vecs[i].exp_cr);
      check({vecs[i].name, "_src_ready"}, src_ready, vecs[i].exp_sr);
      check({vecs[i].name, "_busy"}, busy, vecs[i].exp_busy);
      check({vecs[i].name, "_err"}, err, vecs[i].exp_err);
      check({vecs[i].name, "_done"}, done, 1'b0);
      check({vecs[i].name, "_tok_valid"}, tok_valid, 1'b0);
      check({vecs[i].name, "_tok_cnt"}, tok_cnt, 12'd0);
    end
    start = 1'b0;
    src_valid = 1'b0;
    reset = 1'b1;
    step();
    m_phase = P_IDLE;

    // Full image, sink always ready, 300 tokens with random gaps, last one ends in '$'.
    load_image(-1, -1);
    done_seen = 0;
    n = 0;
    while (n < 300) begin
      v  = ($urandom_range(0, 2) != 0);
      tk = rand_tok();
      if (n == 299) tk[7:0] = 8'h24;
      enc_cycle(v, 1'b1, 1'b0, tk);
      if (v) n++;
    end
    enc_cycle(1'b0, 1'b1, 1'b1, '0);
    drain();
    check("img_tok_cnt", tok_cnt, 12'd300);
    check("img_last_char_nxt", last_pop[7:0], 8'h24);
    check("img_done_once", done_seen, 1);
    check("img_err_clear", err, 2'b00);

    // A token on every ENC cycle: tok_cnt must saturate at 4095.
    load_image(-1, -1);
    for (int k = 0; k < 4100; k++) enc_cycle(1'b1, 1'b1, 1'b0, rand_tok());
    check("sat_tok_cnt", tok_cnt, 12'hfff);
    enc_cycle(1'b0, 1'b1, 1'b1, '0);
    drain();

    // Sink stalled through ENC: the fifth token overflows the 4-entry FIFO.
    load_image(-1, -1);
    done_seen = 0;
    for (int k = 0; k < 10 && m_phase == P_ENC; k++) enc_cycle(1'b1, 1'b0, 1'b0, rand_tok());
    check("ovf_err_code", err, 2'b10);
    check("ovf_flushed", tok_valid, 1'b0);
    drain();
    check("ovf_busy_clear", busy, 1'b0);
    check("ovf_no_done", done_seen, 0);

    // Source drops char 100; then a core strobe while idle must be ignored.
    load_image(100, -1);
    enc_cycle(1'b1, 1'b1, 1'b0, rand_tok());
    check("idle_strobe_not_counted", tok_cnt, 12'd0);

    // Full FIFO with push and pop in the same cycle keeps four entries in order.
    load_image(-1, -1);
    for (int k = 0; k < FD; k++) enc_cycle(1'b1, 1'b0, 1'b0, rand_tok());
    for (int k = 0; k < 3; k++) enc_cycle(1'b1, 1'b1, 1'b0, rand_tok());
    check("full_pushpop_no_err", err, 2'b00);
    check("full_pushpop_still_busy", busy, 1'b1);
    enc_cycle(1'b0, 1'b1, 1'b1, '0);
    drain();
    check("full_pushpop_tok_cnt", tok_cnt, 12'd7);

    // Random core strobes against random sink back-pressure.
    load_image(-1, -1);
    for (int k = 0; k < 200 && m_phase == P_ENC; k++)
      enc_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 1'b0, rand_tok());
    if (m_phase == P_ENC) enc_cycle(1'b0, 1'b1, 1'b1, '0);
    drain();

    // start pulsed mid-LOAD is ignored; reset mid-ENC returns every output to reset values.
    load_image(-1, 50);
    for (int k = 0; k < 3; k++) enc_cycle(1'b1, 1'b0, 1'b0, rand_tok());
    reset     = 1'b0;
    src_valid = 1'b1;
    src_data  = 8'h55;
    step();
    check("rst_enc_core_reset", core_reset, 1'b1);
    check("rst_enc_src_ready", src_ready, 1'b0);
    check("rst_enc_tok_valid", tok_valid, 1'b0);
    check("rst_enc_done", done, 1'b0);
    check("rst_enc_err", err, 2'b00);
    check("rst_enc_tok_cnt", tok_cnt, 12'd0);
    check("rst_enc_busy", busy, 1'b0);
    check("rst_enc_core_char", core_char, 8'h00);
    reset = 1'b1;
    m_phase = P_IDLE;
    mq.delete();
    m_err = 2'b00;
    m_tokcnt = 0;
    step();

    // Stubbed core: no tokens and no finish, so the watchdog must fire.
    load_image(-1, -1);
    done_seen = 0;
    for (int k = 0; k < WDOG + 5 && m_phase == P_ENC; k++) enc_cycle(1'b0, 1'b1, 1'b0, '0);
    check("wdog_err_code", err, 2'b10);
    drain();
    check("wdog_no_done", done_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
